// File: rtl/seg_display_writer_if.sv
// Digit write channel into the trainer display writer.
// The master drives valid/sel/digit and the writer answers with ready.
interface seg_display_writer_if;
  logic       wr_valid;
  logic [1:0] wr_sel;
  logic [3:0] wr_digit;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_digit,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_digit,
    output wr_ready
  );
endinterface

// File: rtl/seg_display_writer.sv
// Writes session digits to the usr/uid/pwd seven-segment displays.
// PWD_MASK_EN: show password digits briefly, then mask them to a dash.
module seg_display_writer #(
  parameter int MASK_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_selector,
  seg_display_writer_if.slave wr,
  output logic                busy,
  output logic [6:0]          seg_usr,
  output logic [6:0]          seg_uid,
  output logic [6:0]          seg_pwd
);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  if (MASK_CYCLES < 1 ||
      longint'(MASK_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("seg_display_writer: MASK_CYCLES must be >= 1 and fit CNT_W");
  end

  // {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef PWD_MASK_EN
  typedef enum logic [1:0] {
    S_OFF, S_READY, S_MASK
  } state_t;

  logic [CNT_W-1:0] cnt;
  logic             busy_q;

  assign busy = busy_q;
`else
  typedef enum logic [1:0] {
    S_OFF, S_READY
  } state_t;

  assign busy = 1'b0;
`endif

  state_t state;
  logic   ready_q;

  assign wr.wr_ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst || !mode_selector) begin
      // reset and session exit both leave everything dark
      state   <= S_OFF;
      ready_q <= 1'b0;
      seg_usr <= BLANK;
      seg_uid <= BLANK;
      seg_pwd <= BLANK;
`ifdef PWD_MASK_EN
      busy_q  <= 1'b0;
      cnt     <= '0;
`endif
    end else begin
      unique case (state)
        S_OFF: begin
          state   <= S_READY;
          ready_q <= 1'b1;
        end
        S_READY: begin
          if (wr.wr_valid) begin
            unique case (wr.wr_sel)
              2'd0: seg_usr <= hex7(wr.wr_digit);
              2'd1: seg_uid <= hex7(wr.wr_digit);
              2'd2: begin
                seg_pwd <= hex7(wr.wr_digit);
`ifdef PWD_MASK_EN
                cnt     <= CNT_W'(MASK_CYCLES - 1);
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
                state   <= S_MASK;
`endif
              end
              default: begin
                seg_usr <= BLANK;
                seg_uid <= BLANK;
                seg_pwd <= BLANK;
              end
            endcase
          end
        end
`ifdef PWD_MASK_EN
        S_MASK: begin
          // writes arriving here are dropped, not queued
          if (cnt == '0) begin
            seg_pwd <= DASH;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_READY;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        default: begin
          state   <= S_OFF;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seg_display_writer.md
Name: seg_display_writer

Overview:
- Drives the three trainer seven-segment displays (user, user-id, password) with digits entered during a session.
- Takes over after the displays have been blanked at mode entry.
- Accepts one digit per valid/ready write, hex-encodes it to active-low segments and holds it.
- Password digits are shown briefly, then masked to a dash.

Parameters:
- MASK_CYCLES, 50000000: cycles a password digit stays visible before masking; legal range is >= 1.
- CNT_W, 26: width of the mask counter; must satisfy 2^CNT_W > MASK_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode_selector  input  1  session enable; 1 = trainer active, 0 = displays off.
- wr_valid  input  1  write request.
- wr_sel  input  2  target: 0 = usr, 1 = uid, 2 = pwd, 3 = clear all.
- wr_digit  input  4  hex digit 0..F; ignored when wr_sel = 3.
- wr_ready  output  1  writer can accept a write this cycle.
- busy  output  1  password mask timer running.
- seg_usr  output  7  user display.
- seg_uid  output  7  user-id display.
- seg_pwd  output  7  password display.

Behaviour:
- Segment format:
  - Bit order is {g,f,e,d,c,b,a}, active-low.
  - Blank = 7'b1111111; dash = 7'b0111111.
- Hex encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- All outputs are registered. Reset values: all three segs = blank, wr_ready = 0, busy = 0, state = OFF, counter = 0.
- State OFF:
  - All segs blank, wr_ready = 0.
  - mode_selector = 1 -> READY on the next edge; segs stay blank.
- State READY:
  - wr_ready = 1. A write is accepted on the edge where wr_valid = 1 and wr_ready = 1.
  - wr_sel 0/1: the target seg shows the encoded digit after that same edge (0-cycle latency after acceptance). Stay in READY.
  - wr_sel 2: seg_pwd shows the encoded digit; counter loads MASK_CYCLES-1; busy = 1; go to MASK.
  - wr_sel 3: all three segs go blank; stay in READY.
- State MASK:
  - wr_ready = 0; any wr_valid is ignored and not queued.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: seg_pwd = dash, busy = 0, go to READY.
  - Net effect: the digit is visible for exactly MASK_CYCLES cycles.
- mode_selector = 0 in any state, including mid-MASK and during a valid write:
  - Go to OFF next edge, blank all segs, clear busy and counter.
  - Overrides a simultaneous write.
- rst overrides everything, including an in-flight mask; outputs return to their reset values on that edge.
- Writing a segment already holding a value overwrites it; no history is kept.
- No wrap or overflow beyond the counter: MASK_CYCLES-1 fits in CNT_W by constraint.

Optional Feature:
- Macro: PWD_MASK_EN.
- Defined: password masking as described above (MASK state, busy, dash).
- Undefined:
  - MASK state and counter are not built; busy is tied to 0.
  - A pwd write behaves like a usr/uid write: the digit stays displayed and wr_ready stays 1.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with mode_selector = 1 -> all segs 1111111, wr_ready = 0, busy = 0; one cycle after rst drops, wr_ready = 1.
- Usr and uid writes: in READY, write sel=0 digit 5, then sel=1 digit A -> seg_usr = 0010010 and seg_uid = 0001000, each after its accept edge; seg_pwd stays 1111111.
- Password mask (MASK_CYCLES = 4, PWD_MASK_EN defined):
  - Write sel=2 digit 7 -> seg_pwd = 1111000 for 4 cycles with busy = 1 and wr_ready = 0.
  - Then seg_pwd = 0111111 and wr_ready = 1.
  - A sel=0 write issued mid-mask is dropped; seg_usr is unchanged.
- Mode drop mid-mask: mode_selector -> 0 two cycles into the mask -> next edge all segs blank, busy = 0, wr_ready = 0; re-raising mode_selector returns to READY with blank displays.
- Clear: after writing digits 3/8/1 to usr/uid/pwd and waiting out the mask, write sel=3 -> all segs 1111111 on the next edge; wr_ready stays 1.
- PWD_MASK_EN undefined: write sel=2 digit F -> seg_pwd = 0001110 indefinitely; busy = 0 throughout; wr_ready = 1 throughout.
